opll_write_sequencer: RTL
=========================

# opll_write_sequencer

Register-write host for the OPLL core's CPU port. Queues (address, data) write requests from a controller (SPI/UART bridge, sequencer ROM or test harness), then replays each one onto the chip-style bus (`din`, `a0`, `cs_n`, `wr_n`). Each bus cycle is paced by the YM2413 master-clock wait rules, so the core never sees a write during its busy window. Sits between the command source and the `ui_in`/`uio_in` bus pins of the OPLL.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: request queue entries; power of two, ≥2.
- `WR_PULSE`, 2: cycles `wr_n` is held low per strobe; ≥1.
- `ADDR_WAIT`, 12: idle cycles after an address strobe before the data phase.
- `DATA_WAIT`, 84: idle cycles after a data strobe before the next write.
- `SKIP_SAME_ADDR`, 1: when 1, omit the address phase if the address equals the last address written.

Ports:
- `clk` in 1: master clock, same clock as the OPLL core.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: write request present.
- `req_ready` out 1: queue can accept; equals `!full`.
- `req_addr` in 8: OPLL register address.
- `req_data` in 8: register data.
- `din` out 8: bus data to the OPLL.
- `a0` out 1: 0 = address phase, 1 = data phase.
- `cs_n` out 1: chip select, active low.
- `wr_n` out 1: write strobe, active low.
- `busy` out 1: `state != IDLE` or queue non-empty.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of queued entries.

## Operation
- Queue: circular FIFO with wrapping read/write pointers and a count. A push occurs when `req_valid && req_ready`. `req_ready` depends only on the current count, so a full FIFO refuses a push even when a pop happens in the same cycle. Simultaneous push and pop in a non-full FIFO leaves the count unchanged.
- FSM states: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_WAIT, DATA_SETUP, DATA_STROBE, DATA_WAIT. A single down-counter times the STROBE and WAIT states.
- IDLE, FIFO non-empty: pop the head into an addr/data holding register.
  - Next state is DATA_SETUP if `SKIP_SAME_ADDR` is 1, `last_valid` is set and the address matches `last_addr`.
  - Otherwise next state is ADDR_SETUP.
- ADDR_SETUP (1 cycle): `din`=addr, `a0`=0, `cs_n`=0, `wr_n`=1.
- ADDR_STROBE (`WR_PULSE` cycles): same as ADDR_SETUP but `wr_n`=0. On exit, update `last_addr` and set `last_valid`.
- ADDR_WAIT (`ADDR_WAIT` cycles): `cs_n`=1, `wr_n`=1, `din` and `a0` held.
- DATA_SETUP (1 cycle): `din`=data, `a0`=1, `cs_n`=0, `wr_n`=1.
- DATA_STROBE (`WR_PULSE` cycles): as DATA_SETUP with `wr_n`=0.
- DATA_WAIT (`DATA_WAIT` cycles): `cs_n`=1, `wr_n`=1, then go to IDLE.
- `din` and `a0` keep their last driven values in IDLE and in the WAIT states.
- `wr_n`=0 only while `cs_n`=0. `din` and `a0` never change while `wr_n`=0.

## Timing
- Reset values: `din`=0, `a0`=0, `cs_n`=1, `wr_n`=1, `busy`=0, `req_ready`=1, `fifo_level`=0. Reset also sets state IDLE, pointers 0 and `last_valid`=0.
- All outputs are registered.
- A request accepted at edge E gives `fifo_level`=1 after E. IDLE pops in the following cycle, so ADDR_SETUP outputs are visible 2 cycles after E.
- Full write with defaults: ADDR_SETUP 1 + ADDR_STROBE 2 + ADDR_WAIT 12 + DATA_SETUP 1 + DATA_STROBE 2 + DATA_WAIT 84 = 102 cycles, plus ≥1 IDLE cycle between writes.
- Skipped-address write: 1 + 2 + 84 = 87 cycles, plus IDLE.
- Reset asserted in any state returns all outputs to their reset values on the next edge. Queued and in-flight writes are discarded, and no partial strobe is completed.

## Test plan
- Reset: hold `rst` for 3 cycles → `cs_n`=`wr_n`=1, `din`=0, `a0`=0, `busy`=0, `req_ready`=1, `fifo_level`=0.
- Single write: push (0x10, 0x55) at cycle 0 → in cycles 2–4 `cs_n`=0, `a0`=0, `din`=0x10, with `wr_n`=0 in cycles 3–4. Cycles 5–16: `cs_n`=1. Cycle 17: `a0`=1, `din`=0x55, `cs_n`=0. Cycles 18–19: `wr_n`=0. Cycles 20–103: `cs_n`=1. `busy` falls at cycle 104.
- Address skip: after the single write, push (0x10, 0x22) → no `a0`=0 strobe; the data strobe carries 0x22. Then push (0x11, 0x01) → full address phase with 0x11.
- Back-pressure: push 6 requests on consecutive cycles with depth 4 → 5 accepted (one popped early). `req_ready`=0 on the 6th; the 6th is accepted later, and all 6 writes appear on the bus in order.
- Reset mid-write: assert `rst` during DATA_STROBE → next cycle `wr_n`=1, `cs_n`=1, `fifo_level`=0. The following write to the same address performs a full address phase.
- Parameters: `WR_PULSE`=1, `ADDR_WAIT`=0, `DATA_WAIT`=1 → write takes 1+1+0+1+1+1 cycles, with strobes exactly 1 cycle wide.

Source files
------------

// File: rtl/opll_write_sequencer.sv
// Queued register-write host for the OPLL CPU port: buffers (address, data)
// requests and replays them as paced address/data bus cycles.
module opll_write_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int WR_PULSE       = 2,
    parameter int ADDR_WAIT      = 12,
    parameter int DATA_WAIT      = 84,
    parameter int SKIP_SAME_ADDR = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7:0]                    req_addr,
    input  logic [7:0]                    req_data,
    output logic [7:0]                    din,
    output logic                          a0,
    output logic                          cs_n,
    output logic                          wr_n,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int MAX_AW  = (WR_PULSE > ADDR_WAIT) ? WR_PULSE : ADDR_WAIT;
    localparam int CNT_MAX = (MAX_AW > DATA_WAIT) ? MAX_AW : DATA_WAIT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] AWAIT_LOAD = CNT_W'((ADDR_WAIT > 0) ? ADDR_WAIT - 1 : 0);
    localparam logic [CNT_W-1:0] DWAIT_LOAD = CNT_W'((DATA_WAIT > 0) ? DATA_WAIT - 1 : 0);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_SETUP,
        S_ADDR_STROBE,
        S_ADDR_WAIT,
        S_DATA_SETUP,
        S_DATA_STROBE,
        S_DATA_WAIT
    } state_t;

    state_t             state;
    logic [15:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   count;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         hold_addr;
    logic [7:0]         hold_data;
    logic [7:0]         last_addr;
    logic               last_valid;

    logic               push;
    logic               pop;
    logic [7:0]         head_addr;
    logic [7:0]         head_data;
    logic               skip_addr;

    // Readiness looks only at the stored count, never at a same-cycle pop.
    assign req_ready  = (count != FULL_LEVEL);
    assign push       = req_valid && req_ready;
    assign pop        = (state == S_IDLE) && (count != '0);
    assign busy       = (state != S_IDLE) || (count != '0);
    assign fifo_level = count;
    assign head_addr  = mem[rd_ptr][15:8];
    assign head_data  = mem[rd_ptr][7:0];
    assign skip_addr  = (SKIP_SAME_ADDR != 0) && last_valid && (head_addr == last_addr);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_addr, req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Bus outputs are loaded on the edge that enters each state, so every
    // pin is a flop and strobes never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            hold_addr  <= '0;
            hold_data  <= '0;
            last_addr  <= '0;
            last_valid <= 1'b0;
            din        <= '0;
            a0         <= 1'b0;
            cs_n       <= 1'b1;
            wr_n       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        hold_addr <= head_addr;
                        hold_data <= head_data;
                        cs_n      <= 1'b0;
                        wr_n      <= 1'b1;
                        if (skip_addr) begin
                            state <= S_DATA_SETUP;
                            din   <= head_data;
                            a0    <= 1'b1;
                        end else begin
                            state <= S_ADDR_SETUP;
                            din   <= head_addr;
                            a0    <= 1'b0;
                        end
                    end
                end

                S_ADDR_SETUP: begin
                    state <= S_ADDR_STROBE;
                    wr_n  <= 1'b0;
                    cnt   <= PULSE_LOAD;
                end

                S_ADDR_STROBE: begin
                    if (cnt == '0) begin
                        last_addr  <= hold_addr;
                        last_valid <= 1'b1;
                        wr_n       <= 1'b1;
                        if (ADDR_WAIT == 0) begin
                            state <= S_DATA_SETUP;
                            din   <= hold_data;
                            a0    <= 1'b1;
                            cs_n  <= 1'b0;
                        end else begin
                            state <= S_ADDR_WAIT;
                            cs_n  <= 1'b1;
                            cnt   <= AWAIT_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_ADDR_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_DATA_SETUP;
                        din   <= hold_data;
                        a0    <= 1'b1;
                        cs_n  <= 1'b0;
                        wr_n  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_DATA_SETUP: begin
                    state <= S_DATA_STROBE;
                    wr_n  <= 1'b0;
                    cnt   <= PULSE_LOAD;
                end

                S_DATA_STROBE: begin
                    if (cnt == '0) begin
                        wr_n <= 1'b1;
                        cs_n <= 1'b1;
                        if (DATA_WAIT == 0) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_DATA_WAIT;
                            cnt   <= DWAIT_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_DATA_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    cs_n  <= 1'b1;
                    wr_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule
